instr_encoder_loader: RTL
=========================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  one-cycle pulse; loads base_addr and begins a load session.
REQ-004 base_addr  in  32  byte address of first instruction word.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream handshake; a transfer occurs when both are high on a rising edge.
REQ-006 ctrl  in  11  control word packed {RegWrite, ImmSrc[1:0], ALUSrc, MemWrite, ResultSrc[1:0], Branch, ALUOp[1:0], Jump}.
REQ-007 rd, rs1, rs2  in  5 each  register fields; funct3  in  3; funct7b5  in  1; imm  in  32 signed byte immediate; last  in  1  marks final instruction.
REQ-008 mem_we / mem_ready  out / in  1 / 1  downstream write handshake; a write completes when both are high.
REQ-009 mem_addr / mem_wdata  out  32 / 32  instruction-memory byte address and encoded word.
REQ-010 busy, done, err  out  1 each; count  out  16  words written this session.

Function
REQ-011 FSM states: IDLE, RUN, DRAIN, DONE, ERR; reset state IDLE.
REQ-012 IDLE: in_ready=0; start -> RUN with wr_addr=base_addr, count=0, err=0, done=0.
REQ-013 ctrl-to-opcode map: 10010010000->0000011; 00111000000->0100011; 10000000100->0110011; 01000001010->1100011; 10010000100->0010011; 11100100001->1101111; any other value is illegal.
REQ-014 Formats: 0000011/0010011 I; 0100011 S; 0110011 R; 1100011 B; 1101111 J; standard RV32I bit placement.
REQ-015 R word: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, opcode}; I-ALU with funct3=101 uses bits[31:25]={1'b0, funct7b5, 5'b0} and imm[4:0].
REQ-016 Range: I/S imm fits signed 12 bits; B fits signed 13 bits with imm[0]=0; J fits signed 21 bits with imm[0]=0; any violation is illegal.
REQ-017 RUN: in_ready = !mem_we || mem_ready (one output register, full throughput).
REQ-018 A legal transfer in cycle N produces mem_we=1 in N+1, with mem_addr=wr_addr and mem_wdata=encoded word; wr_addr then increments by 4.
REQ-019 mem_we, mem_addr and mem_wdata stay stable until mem_ready=1; count increments on each completed write and saturates at 0xFFFF.
REQ-020 wr_addr wraps modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-021 An accepted word with last=1 moves to DRAIN; DRAIN -> DONE when its write completes; done=1 while in DONE; start from DONE begins a new session.
REQ-022 An illegal transfer is not written; it moves to ERR with err=1 and in_ready=0; a pending legal write still completes; only start or rst leaves ERR.
REQ-023 busy=1 in RUN and DRAIN, and in ERR while a write is pending; start outside IDLE/DONE/ERR is ignored.

Reset
REQ-024 rst overrides all inputs, including mid-write: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, done=0, err=0, in_ready=0; a pending write is dropped.

Verification
REQ-025 base 0x100, lw ctrl 10010010000, rd=5, rs1=2, f3=010, imm=8, last=1, mem_ready=1 -> one cycle later addr 0x100, wdata 0x00812283; then done=1, count=1.
REQ-026 Back-to-back R add x3,x1,x2 then sub (funct7b5=1) with mem_ready=1 -> wdata 0x002081B3 at 0x100 and 0x402081B3 at 0x104, one per cycle.
REQ-027 beq x1,x2,imm=-4 -> 0xFE208EE3; jal x1,imm=2048 -> 0x001000EF; jal with imm=3 -> err=1, no write.
REQ-028 mem_ready held 0 for 3 cycles during a stream -> mem_* outputs stable, in_ready=0, no words lost or duplicated.
REQ-029 ctrl=11111111111 -> err=1, ERR state, count unchanged; then start -> RUN with err=0.
REQ-030 base 0xFFFFFFFC, two words -> addresses 0xFFFFFFFC then 0x00000000; rst asserted while mem_we=1 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Purpose: encodes RV32I instructions from decoded control and fields, then writes them to instruction memory.
// Latency: an accepted instruction appears on mem_* one cycle later; there is one output register, so full throughput.
// Backpressure: in_ready drops while a write is held by mem_ready=0; illegal input stops the session in ERR.
// Ports: clk/rst (sync, active-high); start/base_addr open a session; in_valid/in_ready with ctrl, rd, rs1, rs2,
//        funct3, funct7b5, imm, last carry instructions in; mem_we/mem_ready/mem_addr/mem_wdata carry words out;
//        busy/done/err/count report session status.
module instr_encoder_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] ctrl,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  input  logic        last,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [15:0] count_q, count_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        legal;
  logic [31:0] enc_word;
  logic        i_ok, b_ok, j_ok;
  logic        wr_done, accept;

  // An immediate fits N signed bits when every bit above N-2 copies the sign bit.
  assign i_ok = (imm[31:11] == {21{imm[31]}});
  assign b_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
  assign j_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];

  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (ctrl)
      11'b10010010000: begin // load, I-type
        legal    = i_ok;
        enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      end
      11'b10010000100: begin // ALU immediate, I-type; shift-right carries funct7b5 above shamt
        legal = i_ok;
        if (funct3 == 3'b101) enc_word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011};
        else                  enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      11'b00111000000: begin // store, S-type
        legal    = i_ok;
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      end
      11'b10000000100: begin // register ALU, R-type
        legal    = 1'b1;
        enc_word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
      end
      11'b01000001010: begin // branch, B-type
        legal    = b_ok;
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      end
      11'b11100100001: begin // jal, J-type
        legal    = j_ok;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      default: legal = 1'b0;
    endcase
  end

  assign wr_done  = mem_we_q && mem_ready;
  assign in_ready = (state_q == S_RUN) && (!mem_we_q || mem_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    count_d     = count_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (wr_done) begin
      mem_we_d = 1'b0;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_RUN;
          wr_addr_d = base_addr;
          count_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (legal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = enc_word;
            wr_addr_d   = wr_addr_q + 32'd4;
            if (last) state_d = S_DRAIN;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DRAIN: begin
        if (wr_done || !mem_we_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || ((state_q == S_ERR) && mem_we_q);

endmodule
